// File: rtl/mux_pkg.sv
// Shared select encoding for the 4:1 mux and its registered wrapper.
package mux_pkg;

    // Two-bit select code, formed as {s1, s2}.
    typedef logic [1:0] sel_t;

    // Select code for each data input.
    localparam sel_t SEL_I1 = 2'b00;
    localparam sel_t SEL_I2 = 2'b01;
    localparam sel_t SEL_I3 = 2'b10;
    localparam sel_t SEL_I4 = 2'b11;

endpackage : mux_pkg

// File: rtl/mux_mux4_comb.sv
// Purely combinational 4:1 selector. An unknown select yields all-X so that
// select problems propagate visibly in simulation instead of being masked.
module mux4_comb
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  sel_t             sel,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [WIDTH-1:0] i4,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] y_s;

    // Route the addressed data input to the output.
    always_comb begin
        y_s = {WIDTH{1'b0}};
        case (sel)
            SEL_I1:  y_s = i1;
            SEL_I2:  y_s = i2;
            SEL_I3:  y_s = i3;
            SEL_I4:  y_s = i4;
            default: y_s = {WIDTH{1'bx}};
        endcase
    end

    assign y = y_s;

endmodule : mux4_comb

// File: rtl/mux.sv
// 4:1 mux with a live combinational output, an enabled registered copy of
// that output, and a registered flag marking a select change between edges.
module mux
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s1,
    input  logic             s2,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [WIDTH-1:0] i4,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             sel_chg
);

    sel_t             sel_s;
    sel_t             sel_q;
    sel_t             sel_d;
    logic [WIDTH-1:0] y_q_q;
    logic [WIDTH-1:0] y_q_d;
    logic             sel_chg_q;
    logic             sel_chg_d;

    assign sel_s = {s1, s2};

    mux4_comb #(
        .WIDTH (WIDTH)
    ) u_mux4_comb (
        .sel (sel_s),
        .i1  (i1),
        .i2  (i2),
        .i3  (i3),
        .i4  (i4),
        .y   (y)
    );

    // Next-state: load y when enabled, always track select and flag changes.
    always_comb begin
        y_q_d     = y_q_q;
        sel_d     = sel_s;
        sel_chg_d = 1'b0;
        if (en) begin
            y_q_d = y;
        end else begin
            y_q_d = y_q_q;
        end
        if (sel_s != sel_q) begin
            sel_chg_d = 1'b1;
        end else begin
            sel_chg_d = 1'b0;
        end
    end

    // State registers; reset clears everything immediately, without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q_q     <= {WIDTH{1'b0}};
            sel_q     <= SEL_I1;
            sel_chg_q <= 1'b0;
        end else begin
            y_q_q     <= y_q_d;
            sel_q     <= sel_d;
            sel_chg_q <= sel_chg_d;
        end
    end

    assign y_q     = y_q_q;
    assign sel_chg = sel_chg_q;

endmodule : mux

// File: tb/tb_mux.sv
// Scoreboard bench for mux: stimulus queues expected values, a monitor
// process samples the DUT outputs and compares them.
module tb_mux;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s1, s2, en;
    logic [W-1:0] i1, i2, i3, i4;
    logic [W-1:0] y, y_q;
    logic         sel_chg;

    typedef struct {
        string      name;
        logic [1:0] kind;  // 0: y, 1: y_q, 2: sel_chg
        logic [W-1:0] exp;
    } exp_t;

    exp_t sb_q[$];
    logic sample_req = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mux #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s1      (s1),
        .s2      (s2),
        .i1      (i1),
        .i2      (i2),
        .i3      (i3),
        .i4      (i4),
        .en      (en),
        .y       (y),
        .y_q     (y_q),
        .sel_chg (sel_chg)
    );

    always #5 clk = ~clk;

    task automatic expect_out(input string name, input logic [1:0] kind, input logic [W-1:0] exp);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    // Hand the queued expectations to the monitor and let it sample.
    task automatic sample();
        sample_req = ~sample_req;
        #2;
    endtask

    task automatic set_sel(input logic [1:0] s);
        {s1, s2} = s;
    endtask

    // Monitor: on each request, sample outputs and compare to the queue head.
    initial begin
        exp_t         e;
        logic [W-1:0] act;
        forever begin
            @(sample_req);
            #1;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                case (e.kind)
                    2'd0:    act = y;
                    2'd1:    act = y_q;
                    2'd2:    act = {{(W-1){1'b0}}, sel_chg};
                    default: act = {W{1'bx}};
                endcase
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h, expected %h at t=%0t", e.name, act, e.exp, $time);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        set_sel(2'b00);
        i1 = 8'h00; i2 = 8'h00; i3 = 8'h00; i4 = 8'h00;

        // Reset state.
        #1;
        expect_out("reset_y_q", 2'd1, 8'h00);
        expect_out("reset_sel_chg", 2'd2, 8'h00);
        expect_out("reset_y", 2'd0, 8'h00);
        sample();
        @(negedge clk);
        rst_n = 1'b1;

        // One-hot data sweep across all selects, 5 time units apart.
        for (int d = 0; d < 4; d++) begin
            for (int s = 0; s < 4; s++) begin
                i1 = (d == 0) ? 8'h01 : 8'h00;
                i2 = (d == 1) ? 8'h01 : 8'h00;
                i3 = (d == 2) ? 8'h01 : 8'h00;
                i4 = (d == 3) ? 8'h01 : 8'h00;
                set_sel(s[1:0]);
                #3;
                expect_out($sformatf("onehot_d%0d_s%0d", d, s), 2'd0, (s == d) ? 8'h01 : 8'h00);
                sample();
            end
        end

        // Enabled load then hold.
        @(negedge clk);
        i1 = 8'h00; i2 = 8'h00; i3 = 8'h00; i4 = 8'h01;
        set_sel(2'b11);
        en = 1'b1;
        @(posedge clk);
        #1;
        expect_out("load_y_q", 2'd1, 8'h01);
        sample();
        @(negedge clk);
        en = 1'b0;
        i4 = 8'h00;
        #1;
        expect_out("hold_y", 2'd0, 8'h00);
        sample();
        @(posedge clk);
        #1;
        expect_out("hold_y_q", 2'd1, 8'h01);
        sample();

        // Asynchronous reset mid-cycle with y_q=1; y stays live.
        @(negedge clk);
        i4 = 8'h01;
        #2;
        rst_n = 1'b0;
        expect_out("async_rst_y_q", 2'd1, 8'h00);
        expect_out("async_rst_sel_chg", 2'd2, 8'h00);
        expect_out("async_rst_y", 2'd0, 8'h01);
        sample();
        en = 1'b1;
        @(posedge clk);
        #1;
        expect_out("rst_hold_y_q", 2'd1, 8'h00);
        sample();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        expect_out("deassert_no_change", 2'd1, 8'h00);
        sample();
        @(posedge clk);
        #1;
        expect_out("first_load_after_rst", 2'd1, 8'h01);
        sample();

        // Select-change flag: 01 held for two edges, then 10, then held.
        @(negedge clk);
        en = 1'b0;
        set_sel(2'b01);
        @(posedge clk);
        #1;
        expect_out("sel_chg_11_to_01", 2'd2, 8'h01);
        sample();
        @(posedge clk);
        #1;
        expect_out("sel_chg_hold01", 2'd2, 8'h00);
        sample();
        @(negedge clk);
        set_sel(2'b10);
        @(posedge clk);
        #1;
        expect_out("sel_chg_to10", 2'd2, 8'h01);
        sample();
        @(posedge clk);
        #1;
        expect_out("sel_chg_hold10", 2'd2, 8'h00);
        sample();

        // Wide data: non-selected input changes do not reach y or y_q.
        @(negedge clk);
        i1 = 8'h00; i2 = 8'h00; i3 = 8'hA5; i4 = 8'h00;
        #1;
        expect_out("wide_y_a5", 2'd0, 8'hA5);
        sample();
        i1 = 8'hFF;
        #1;
        expect_out("wide_y_i1_ignored", 2'd0, 8'hA5);
        sample();
        en = 1'b1;
        @(posedge clk);
        #1;
        expect_out("wide_y_q_a5", 2'd1, 8'hA5);
        sample();
        i1 = 8'h3C;
        @(posedge clk);
        #1;
        expect_out("wide_y_q_i1_ignored", 2'd1, 8'hA5);
        sample();

        // Select and data change together; y_q takes the post-change value.
        @(negedge clk);
        set_sel(2'b00);
        i1 = 8'h5A;
        @(posedge clk);
        #1;
        expect_out("joint_change_y_q", 2'd1, 8'h5A);
        expect_out("joint_change_y", 2'd0, 8'h5A);
        sample();

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 20 && sb_q.size() > 0; k++) #1;
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog against a stalled run.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_mux
